// File: rtl/pet_clk_pkg.sv
// pet_clk_pkg: shared constants and helpers
// for the PET clock-enable generator.
package pet_clk_pkg;

  localparam int DEF_BASE_DIV  = 56;
  localparam int DEF_TURBO_DIV = 3;
  localparam int DEF_PIX_DIV   = 8;

  typedef enum logic {
    STALL_DROP  = 1'b0,
    STALL_DEFER = 1'b1
  } stall_mode_e;

  function automatic int div_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int clamp_sel(
    input int s,
    input int n
  );
    return (s >= n) ? n - 1 : s;
  endfunction

endpackage

// File: rtl/pet_ce_div.sv
// pet_ce_div: modulo-N counter with two registered
// compare enables and a hold-at-terminal input.
module pet_ce_div
  import pet_clk_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] period,
  input  logic [W-1:0] cmp_a,
  input  logic [W-1:0] cmp_b,
  input  logic         hold,
  input  logic         kill,
  output logic         at_term,
  output logic         ce_a,
  output logic         ce_b
);

  logic [W-1:0] cnt;

  assign at_term = (cnt == period - W'(1));

  // advance, wrap at terminal unless held there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (at_term) begin
      if (!hold) cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // compare hits, registered; masked when held or killed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_a <= 1'b0;
      ce_b <= 1'b0;
    end else begin
      ce_a <= (cnt == cmp_a) && !hold && !kill;
      ce_b <= (cnt == cmp_b) && !hold && !kill;
    end
  end

endmodule

// File: rtl/pet_ce_gen.sv
// pet_ce_gen: pixel and CPU clock enables for the PET
// system clock domain, with speed, turbo and stall control.
module pet_ce_gen
  import pet_clk_pkg::*;
#(
  parameter  int BASE_DIV   = DEF_BASE_DIV,
  parameter  int NUM_SPEEDS = 4,
  parameter  int TURBO_DIV  = DEF_TURBO_DIV,
  parameter  int PIX_DIV    = DEF_PIX_DIV,
  parameter  int STALL_MODE = 1,
  parameter  int MIN_DIV    = 2,
  localparam int SEL_W      =
    (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
  localparam int DIV_W      = div_w(BASE_DIV),
  localparam int PIX_W      = div_w(PIX_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] speed_sel,
  input  logic             turbo_req,
  input  logic             stall,
  output logic             ce_pix_p,
  output logic             ce_pix_n,
  output logic             ce_cpu,
  output logic [DIV_W-1:0] cur_period,
  output logic             stalled
);

  localparam stall_mode_e MODE =
    (STALL_MODE != 0) ? STALL_DEFER : STALL_DROP;
  localparam bit DEFER = (MODE == STALL_DEFER);

  int               req_i;
  logic [DIV_W-1:0] req;
  logic             cpu_term;
  logic             cpu_hold;
  logic             cpu_wrap;
  logic             pix_term_unused;
  logic             cpu_half_unused;

  assign cpu_hold = DEFER && stall;
  assign cpu_wrap = cpu_term && !cpu_hold;

  // free-running pixel divider, two phases
  pet_ce_div #(.W(PIX_W)) u_pix (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (PIX_W'(PIX_DIV)),
    .cmp_a   ('0),
    .cmp_b   (PIX_W'(PIX_DIV / 2)),
    .hold    (1'b0),
    .kill    (1'b0),
    .at_term (pix_term_unused),
    .ce_a    (ce_pix_p),
    .ce_b    (ce_pix_n)
  );

  // CPU divider; enable sits on the terminal count
  pet_ce_div #(.W(DIV_W)) u_cpu (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (cur_period),
    .cmp_a   (cur_period - DIV_W'(1)),
    .cmp_b   ('0),
    .hold    (cpu_hold),
    .kill    (stall),
    .at_term (cpu_term),
    .ce_a    (ce_cpu),
    .ce_b    (cpu_half_unused)
  );

  // requested period: turbo first, then speed table, floored
  always_comb begin
    req_i = BASE_DIV >> clamp_sel(int'(speed_sel), NUM_SPEEDS);
    if (turbo_req) req_i = TURBO_DIV;
    if (req_i < MIN_DIV) req_i = MIN_DIV;
    req = DIV_W'(req_i);
  end

  // period reload at boundaries only; stall flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_period <= DIV_W'(BASE_DIV);
      stalled    <= 1'b0;
    end else begin
      if (cpu_wrap) cur_period <= req;
      stalled <= cpu_term && stall;
    end
  end

endmodule

// File: tb/tb_pet_ce_gen.sv
// tb_pet_ce_gen: random and directed checks of both stall
// modes against a cycle-count reference model.
module tb_pet_ce_gen;

  localparam int BASE  = 56;
  localparam int PIX   = 8;
  localparam int TURBO = 3;
  localparam int MINP  = 2;
  localparam int NSP   = 4;
  localparam int DW    = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    speed_sel = 2'd0;
  logic          turbo_req = 1'b0;
  logic          stall = 1'b0;

  logic          d_pp, d_pn, d_ce, d_st;
  logic [DW-1:0] d_per;
  logic          r_pp, r_pn, r_ce, r_st;
  logic [DW-1:0] r_per;

  pet_ce_gen #(.STALL_MODE(1)) dut_defer (
    .clk        (clk),
    .reset_n    (reset_n),
    .speed_sel  (speed_sel),
    .turbo_req  (turbo_req),
    .stall      (stall),
    .ce_pix_p   (d_pp),
    .ce_pix_n   (d_pn),
    .ce_cpu     (d_ce),
    .cur_period (d_per),
    .stalled    (d_st)
  );

  pet_ce_gen #(.STALL_MODE(0)) dut_drop (
    .clk        (clk),
    .reset_n    (reset_n),
    .speed_sel  (speed_sel),
    .turbo_req  (turbo_req),
    .stall      (stall),
    .ce_pix_p   (r_pp),
    .ce_pix_n   (r_pn),
    .ce_cpu     (r_ce),
    .cur_period (r_per),
    .stalled    (r_st)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: edges since release, age in period, period
  int t;
  int a_d, p_d, a_r, p_r;
  bit e_pp, e_pn, e_cd, e_sd, e_cr, e_sr;

  // event bookkeeping (cycle numbers)
  int cyc, d_last, d_int, d_n, r_last, r_int, r_n;
  int d_stc, r_stc, first_pp, first_ce;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int req_of(input bit tb, input int s);
    int r;
    int ss;
    ss = (s >= NSP) ? NSP - 1 : s;
    r = tb ? TURBO : BASE / (2 ** ss);
    if (r < MINP) r = MINP;
    return r;
  endfunction

  task automatic mdl_reset();
    t = 0;
    a_d = 0; p_d = BASE;
    a_r = 0; p_r = BASE;
    e_pp = 0; e_pn = 0;
    e_cd = 0; e_sd = 0;
    e_cr = 0; e_sr = 0;
  endtask

  task automatic cpu_mdl(input bit defer,
                         inout int age, inout int per,
                         output bit ce, output bit st);
    bit term;
    term = (age == per - 1);
    ce = 0;
    st = 0;
    if (!term) begin
      age++;
    end else if (stall && defer) begin
      st = 1;
    end else begin
      ce = !stall;
      st = stall;
      age = 0;
      per = req_of(turbo_req, int'(speed_sel));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      mdl_reset();
    end else begin
      t++;
      e_pp = ((t - 1) % PIX) == 0;
      e_pn = ((t - 1) % PIX) == PIX / 2;
      cpu_mdl(1'b1, a_d, p_d, e_cd, e_sd);
      cpu_mdl(1'b0, a_r, p_r, e_cr, e_sr);
    end
    #1;
    cyc++;
    chk("pix_p", int'(d_pp), int'(e_pp));
    chk("pix_n", int'(d_pn), int'(e_pn));
    chk("pix_p_drop", int'(r_pp), int'(e_pp));
    chk("pix_n_drop", int'(r_pn), int'(e_pn));
    chk("ce_defer", int'(d_ce), int'(e_cd));
    chk("st_defer", int'(d_st), int'(e_sd));
    chk("per_defer", int'(d_per), p_d);
    chk("ce_drop", int'(r_ce), int'(e_cr));
    chk("st_drop", int'(r_st), int'(e_sr));
    chk("per_drop", int'(r_per), p_r);
    if (d_pp && first_pp < 0) first_pp = cyc;
    if (d_ce) begin
      d_int = cyc - d_last;
      d_last = cyc;
      d_n++;
      if (first_ce < 0) first_ce = cyc;
    end
    if (r_ce) begin
      r_int = cyc - r_last;
      r_last = cyc;
      r_n++;
    end
    if (d_st) d_stc++;
    if (r_st) r_stc++;
  endtask

  task automatic wait_ce_d(input string tag);
    int n0;
    n0 = d_n;
    for (int i = 0; i < 400 && d_n == n0; i++) step();
    chk(tag, int'(d_n != n0), 1);
  endtask

  task automatic wait_ce_r(input string tag);
    int n0;
    n0 = r_n;
    for (int i = 0; i < 400 && r_n == n0; i++) step();
    chk(tag, int'(r_n != n0), 1);
  endtask

  task automatic wait_age(input int a);
    for (int i = 0; i < 400 && a_d != a; i++) step();
    chk("reach_age", a_d, a);
  endtask

  task automatic wait_term();
    for (int i = 0; i < 400 && a_d != p_d - 1; i++) step();
    chk("reach_term", a_d, p_d - 1);
  endtask

  task automatic chk_zero(input string sfx);
    chk({"z_pp", sfx}, int'(d_pp), 0);
    chk({"z_pn", sfx}, int'(d_pn), 0);
    chk({"z_ce", sfx}, int'(d_ce), 0);
    chk({"z_st", sfx}, int'(d_st), 0);
    chk({"z_per", sfx}, int'(d_per), BASE);
    chk({"z_ce_drop", sfx}, int'(r_ce), 0);
    chk({"z_st_drop", sfx}, int'(r_st), 0);
    chk({"z_per_drop", sfx}, int'(r_per), BASE);
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    d_last = 0;
    r_last = 0;
    first_pp = -1;
    first_ce = -1;
  endtask

  initial begin
    cyc = 0; d_n = 0; r_n = 0;
    d_int = 0; r_int = 0;
    d_stc = 0; r_stc = 0;
    mdl_reset();
    #1 reset_n = 1'b0;
    #11;
    chk_zero("_rst");
    release_rst();

    // nominal speed 0
    wait_ce_d("ce_s0_a");
    chk("first_ce", first_ce, BASE);
    chk("first_pp", first_pp, 1);
    wait_ce_d("ce_s0_b");
    chk("int_s0", d_int, BASE);

    // speed change mid-period
    wait_age(20);
    speed_sel = 2'd3;
    wait_ce_d("ce_chg");
    chk("int_chg", d_int, BASE);
    wait_ce_d("ce_s3");
    chk("int_s3", d_int, 7);
    chk("per_s3", int'(d_per), 7);

    // turbo over speed 1
    speed_sel = 2'd1;
    wait_ce_d("ce_s1_a");
    wait_ce_d("ce_s1_b");
    chk("int_s1", d_int, 28);
    turbo_req = 1'b1;
    wait_ce_d("ce_tb_a");
    wait_ce_d("ce_tb_b");
    chk("int_turbo", d_int, TURBO);
    chk("per_turbo", int'(d_per), TURBO);
    turbo_req = 1'b0;
    wait_ce_d("ce_nt_a");
    wait_ce_d("ce_nt_b");
    chk("int_noturbo", d_int, 28);
    chk("per_noturbo", int'(d_per), 28);

    // 10-cycle stall at terminal, both modes
    speed_sel = 2'd0;
    wait_ce_d("ce_pre_a");
    wait_ce_d("ce_pre_b");
    wait_term();
    d_stc = 0;
    r_stc = 0;
    stall = 1'b1;
    repeat (10) step();
    stall = 1'b0;
    wait_ce_d("ce_defer");
    chk("int_defer", d_int, BASE + 10);
    chk("stc_defer", d_stc, 10);
    wait_ce_r("ce_drop");
    chk("int_drop", r_int, 2 * BASE);
    chk("stc_drop", r_stc, 1);
    wait_ce_d("ce_post");
    chk("int_post", d_int, BASE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      stall = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0)
        speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        turbo_req = ~turbo_req;
    end

    // reset while held at terminal
    stall = 1'b0;
    turbo_req = 1'b0;
    speed_sel = 2'd0;
    wait_ce_d("ce_pre_rst");
    wait_term();
    stall = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk_zero("_async");
    mdl_reset();
    repeat (2) step();
    stall = 1'b0;
    release_rst();
    wait_ce_d("ce_after_rst");
    chk("first_ce_rst", first_ce, BASE);
    chk("first_pp_rst", first_pp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pet_ce_gen.md
Name: pet_ce_gen

Overview:
Parametrised clock-enable generator for the PET system clock domain. Produces the two-phase pixel enables and a CPU enable whose period is selected from a power-of-two speed table, with a tape-turbo override and memory-stall handling. The stall can either drop the CPU cycle or defer it. Speed changes are applied only at CPU period boundaries, so no enable is ever truncated or doubled. It sits between the system PLL clock and the CPU, video mixer and tape logic.

Parameters:
- BASE_DIV, 56: clk cycles per CPU enable at speed 0 (56 MHz / 56 = 1 MHz).
- NUM_SPEEDS, 4: number of speed settings. Period for setting s = BASE_DIV >> s.
- TURBO_DIV, 3: CPU period while turbo_req is high.
- PIX_DIV, 8: clk cycles per pixel enable. Must be even and ≥ 2.
- STALL_MODE, 1: 0 = drop the CPU enable while stalled; 1 = defer it until the stall clears.
- MIN_DIV, 2: floor applied to every computed period.

Ports:
- clk  in  1  system clock (56 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- speed_sel  in  $clog2(NUM_SPEEDS)  requested CPU speed index.
- turbo_req  in  1  tape fast-load override; takes priority over speed_sel.
- stall  in  1  memory not ready; level-sensitive.
- ce_pix_p  out  1  pixel enable, rising phase.
- ce_pix_n  out  1  pixel enable, falling phase.
- ce_cpu  out  1  CPU enable, one clk wide.
- cur_period  out  DIV_W  period currently in force. DIV_W = $clog2(BASE_DIV+1).
- stalled  out  1  a CPU enable is being held or was dropped.

Behaviour:
- Reset (async assert, sync release): all outputs 0; pix_cnt = 0; cpu_cnt = 0; cur_period = BASE_DIV.
- All outputs are registered, giving one cycle of latency from the counter state.
- Pixel divider:
  - pix_cnt counts 0..PIX_DIV-1 and wraps.
  - ce_pix_p = 1 in the cycle after pix_cnt == 0.
  - ce_pix_n = 1 in the cycle after pix_cnt == PIX_DIV/2.
  - The pixel divider is never affected by stall, turbo or speed.
- Requested period:
  - req = TURBO_DIV if turbo_req is high, else BASE_DIV >> speed_sel.
  - The result is clamped to ≥ MIN_DIV.
  - A speed_sel value ≥ NUM_SPEEDS is treated as NUM_SPEEDS-1.
- CPU divider:
  - cpu_cnt counts 0..cur_period-1.
  - The terminal count is cur_period-1.
  - At terminal with stall low: ce_cpu = 1 on the next cycle, cpu_cnt → 0, and cur_period ← req (sampled in this cycle).
- Stall handling at terminal count:
  - STALL_MODE = 0: the counter wraps and cur_period updates as normal. ce_cpu is suppressed and stalled is high for one cycle.
  - STALL_MODE = 1: cpu_cnt holds at terminal and stalled stays high while stall is high. In the first cycle with stall low, the deferred ce_cpu fires, stalled clears, and the counter wraps and reloads as normal.
- Stall asserted at any non-terminal count has no effect; only the value at terminal matters.
- Speed or turbo changes mid-period never shorten or lengthen the running period. The new value takes effect from the next period.
- Simultaneous turbo_req and speed_sel change: turbo wins.
- A reset mid-period or mid-stall discards the pending enable and restarts from the reset state.
- ce_cpu is never high in two consecutive cycles, because MIN_DIV ≥ 2.

Decomposition:
- Package pet_clk_pkg holds:
  - the default constants (BASE_DIV, TURBO_DIV, PIX_DIV);
  - the DIV_W computation function;
  - stall-mode enum stall_mode_e {STALL_DROP, STALL_DEFER}.
- Sub-module pet_ce_div: a generic modulo-N counter with a registered one-cycle enable output and a hold input.
  - Instantiated once for the pixel divider, with hold tied low and a second compare at N/2.
  - Instantiated once for the CPU divider, with hold = stall at terminal in defer mode.

Test Plan:
- Speed and pixel rates: speed_sel = 0, turbo 0, stall 0 → ce_cpu every 56 clks, ce_pix_p every 8 clks, ce_pix_n 4 clks after ce_pix_p, cur_period = 56.
- Speed change mid-period: switch speed_sel 0 → 3 at cpu_cnt = 20 → the next ce_cpu arrives exactly 56 clks after the previous one, then every 7 clks; cur_period = 7 from that wrap.
- Turbo override: turbo_req = 1 with speed_sel = 1 → period 3 from the next boundary; dropping turbo returns the period to 28.
- Defer stall (STALL_MODE = 1): stall high for 10 clks starting at terminal → ce_cpu is delayed 10 clks, stalled is high for 10 clks, no enable is lost, and the following period is a full 56.
- Drop stall (STALL_MODE = 0): stall high at terminal → that ce_cpu is absent, stalled pulses for 1 clk, and the next ce_cpu lands 56 clks later.
- Reset mid-stall: assert reset_n low while held at terminal in defer mode → all outputs 0 immediately; after release, first ce_pix_p at clk 1 and first ce_cpu 56 clks later.
